// File: rtl/regfile_write_scheduler.sv
// Write-port scheduler for the register file: zero-fills x0..x31 after reset, then
// arbitrates the ALU writeback (highest priority) against a small buffered-load FIFO.
module regfile_write_scheduler #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [4:0]      addr_rs1,
  input  logic [4:0]      addr_rs2,
  output logic            rs1_pending,
  output logic            rs2_pending,
  output logic            write_enable,
  output logic [4:0]      addr_rd,
  output logic [XLEN-1:0] data_rd,
  output logic            init_done
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        clr_q, clr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [4:0]        ent_rd_q   [DEPTH];
  logic [4:0]        ent_rd_d   [DEPTH];
  logic [XLEN-1:0]   ent_data_q [DEPTH];
  logic [XLEN-1:0]   ent_data_d [DEPTH];
  logic [DEPTH-1:0]  ent_vld_q, ent_vld_d;

  logic              alu_w;
  logic              pop;
  logic              accept;
  logic              enq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Next-state, FIFO update and combinational write-port outputs.
  always_comb begin
    state_d      = state_q;
    clr_d        = clr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ent_rd_d     = ent_rd_q;
    ent_data_d   = ent_data_q;
    ent_vld_d    = ent_vld_q;
    ld_ready     = 1'b0;
    rs1_pending  = 1'b0;
    rs2_pending  = 1'b0;
    write_enable = 1'b0;
    addr_rd      = '0;
    data_rd      = '0;
    init_done    = 1'b0;
    alu_w        = alu_valid && (alu_rd != 5'd0);
    pop          = 1'b0;
    accept       = 1'b0;
    enq          = 1'b0;

    case (state_q)
      ST_INIT: begin
        write_enable = 1'b1;
        addr_rd      = clr_q;
        clr_d        = clr_q + 5'd1;
        if (clr_q == 5'd31) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        init_done = 1'b1;
        ld_ready  = (count_q < CW'(DEPTH));
        pop       = !alu_w && (count_q != '0);
        accept    = ld_valid && ld_ready;
        enq       = accept && (ld_rd != 5'd0) && !(alu_w && (alu_rd == ld_rd));

        if (alu_w) begin
          write_enable = 1'b1;
          addr_rd      = alu_rd;
          data_rd      = alu_data;
        end else if (pop && ent_vld_q[rd_ptr_q]) begin
          write_enable = 1'b1;
          addr_rd      = ent_rd_q[rd_ptr_q];
          data_rd      = ent_data_q[rd_ptr_q];
        end

        // Younger ALU write kills older buffered loads to the same rd.
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (alu_w && (ent_rd_q[i] == alu_rd)) begin
            ent_vld_d[i] = 1'b0;
          end
          if (ent_vld_q[i] && (addr_rs1 != 5'd0) && (ent_rd_q[i] == addr_rs1)) begin
            rs1_pending = 1'b1;
          end
          if (ent_vld_q[i] && (addr_rs2 != 5'd0) && (ent_rd_q[i] == addr_rs2)) begin
            rs2_pending = 1'b1;
          end
        end

        if (pop) begin
          ent_vld_d[rd_ptr_q] = 1'b0;
          rd_ptr_d            = ptr_inc(rd_ptr_q);
        end
        if (enq) begin
          ent_vld_d[wr_ptr_q]  = 1'b1;
          ent_rd_d[wr_ptr_q]   = ld_rd;
          ent_data_d[wr_ptr_q] = ld_data;
          wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        count_d = count_q + CW'(enq) - CW'(pop);
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Outputs stay quiet while reset is held, including the x0 clear.
    if (reset) begin
      ld_ready     = 1'b0;
      rs1_pending  = 1'b0;
      rs2_pending  = 1'b0;
      write_enable = 1'b0;
      addr_rd      = '0;
      data_rd      = '0;
      init_done    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      clr_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ent_vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ent_vld_q  <= ent_vld_d;
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Randomized bench for regfile_write_scheduler against a queue-based model of the
// zero-fill / ALU-priority / buffered-load rules.
module tb_regfile_write_scheduler;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clock;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [4:0]      addr_rs1;
  logic [4:0]      addr_rs2;
  logic            rs1_pending;
  logic            rs2_pending;
  logic            write_enable;
  logic [4:0]      addr_rd;
  logic [XLEN-1:0] data_rd;
  logic            init_done;

  regfile_write_scheduler #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .addr_rs1     (addr_rs1),
    .addr_rs2     (addr_rs2),
    .rs1_pending  (rs1_pending),
    .rs2_pending  (rs2_pending),
    .write_enable (write_enable),
    .addr_rd      (addr_rd),
    .data_rd      (data_rd),
    .init_done    (init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    bit              live;
  } ent_t;

  ent_t            fifo[$];
  int              init_cnt;
  logic [XLEN-1:0] dut_rf [32];
  logic [XLEN-1:0] mdl_rf [32];
  int              n_checks;
  int              n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=0x%0h exp=0x%0h", tag, $time, got, exp);
    end
  endtask

  // Compare outputs for the current cycle, then advance the model across the next edge.
  task automatic cycle_check();
    logic            e_we, e_rdy, e_done, e_p1, e_p2, alu_w, acc;
    logic [4:0]      e_addr;
    logic [XLEN-1:0] e_data;
    #1;
    e_we = 0; e_rdy = 0; e_done = 0; e_p1 = 0; e_p2 = 0;
    e_addr = '0; e_data = '0;
    alu_w = alu_valid && (alu_rd != 5'd0);
    if (reset) begin
      fifo.delete();
      init_cnt = 0;
    end else if (init_cnt < 32) begin
      e_we   = 1;
      e_addr = 5'(init_cnt);
    end else begin
      e_done = 1;
      e_rdy  = (fifo.size() < DEPTH);
      if (alu_w) begin
        e_we = 1; e_addr = alu_rd; e_data = alu_data;
      end else if (fifo.size() > 0 && fifo[0].live) begin
        e_we = 1; e_addr = fifo[0].rd; e_data = fifo[0].data;
      end
      foreach (fifo[i]) begin
        if (fifo[i].live && addr_rs1 != 5'd0 && fifo[i].rd == addr_rs1) e_p1 = 1;
        if (fifo[i].live && addr_rs2 != 5'd0 && fifo[i].rd == addr_rs2) e_p2 = 1;
      end
    end

    check_eq("write_enable", 64'(write_enable), 64'(e_we));
    check_eq("addr_rd",      64'(addr_rd),      64'(e_addr));
    check_eq("data_rd",      64'(data_rd),      64'(e_data));
    check_eq("ld_ready",     64'(ld_ready),     64'(e_rdy));
    check_eq("init_done",    64'(init_done),    64'(e_done));
    check_eq("rs1_pending",  64'(rs1_pending),  64'(e_p1));
    check_eq("rs2_pending",  64'(rs2_pending),  64'(e_p2));

    if (!reset) begin
      if (write_enable) dut_rf[addr_rd] = data_rd;
      if (e_we) mdl_rf[e_addr] = e_data;
      if (init_cnt < 32) begin
        init_cnt++;
      end else begin
        acc = ld_valid && e_rdy;
        if (alu_w) begin
          foreach (fifo[i]) if (fifo[i].rd == alu_rd) fifo[i].live = 0;
        end else if (fifo.size() > 0) begin
          void'(fifo.pop_front());
        end
        if (acc && ld_rd != 5'd0 && !(alu_w && alu_rd == ld_rd))
          fifo.push_back('{rd: ld_rd, data: ld_data, live: 1'b1});
      end
    end
  endtask

  task automatic drive_random(input int alu_pct, input int ld_pct);
    alu_valid = ($urandom_range(99) < 32'(alu_pct));
    alu_rd    = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(7));
    alu_data  = $urandom;
    ld_valid  = ($urandom_range(99) < 32'(ld_pct));
    ld_rd     = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(7));
    ld_data   = $urandom;
    addr_rs1  = 5'($urandom_range(7));
    addr_rs2  = 5'($urandom_range(7));
  endtask

  task automatic run_phase(input int alu_pct, input int ld_pct, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      drive_random(alu_pct, ld_pct);
      cycle_check();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    init_cnt = 0;
    for (int r = 0; r < 32; r++) begin
      dut_rf[r] = 32'hDEAD_BEEF;
      mdl_rf[r] = 32'hDEAD_BEEF;
    end
    reset = 1'b1;
    drive_random(50, 50);

    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      drive_random(50, 50);
      cycle_check();
    end
    @(negedge clock);
    reset = 1'b0;
    drive_random(90, 90);
    cycle_check();

    run_phase(90, 90, 40);
    run_phase(30, 60, 300);
    run_phase(80, 90, 200);
    run_phase(5, 40, 200);
    run_phase(50, 50, 300);

    // Fill the FIFO behind a busy ALU, then reset asynchronously mid-operation.
    run_phase(100, 100, 6);
    @(negedge clock);
    reset = 1'b1;
    cycle_check();
    @(negedge clock);
    cycle_check();
    @(negedge clock);
    reset = 1'b0;
    drive_random(50, 50);
    cycle_check();
    run_phase(50, 50, 150);
    run_phase(0, 0, 10);

    for (int r = 0; r < 32; r++) begin
      check_eq($sformatf("rf_x%0d", r), 64'(dut_rf[r]), 64'(mdl_rf[r]));
    end
    check_eq("rf_x0_zero", 64'(dut_rf[0]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
